timer_bank: RTL and testbench

Parametrised multi-channel countdown timer with a memory-mapped register interface, per-channel interrupt pending/mask and an aggregated interrupt output. It sits behind the system bridge as one peripheral slot and feeds the CPU hardware-interrupt inputs. It replaces fixed single-channel timer instances with one bank of `NUM_CH` channels. Each channel supports one-shot and auto-reload modes, and the bank adds a write-1-to-clear pending register.

---
 rtl/timer_bank.sv | 155 +++++++++++++++
 tb/tb_timer_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH independent countdown timers behind a word-addressed
// register file. Each channel is a four-state FSM (IDLE/LOAD/CNT/INT) with a
// preset, a live count and a one-shot or auto-reload mode. Expirations set a
// shared write-1-to-clear pending register. Unmasked pending bits drive irq_vec
// and the aggregated irq.
module timer_bank #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PEND_ADDR = ADDR_W'(4 * NUM_CH);
  localparam logic [1:0]        MODE_AUTO = 2'b01;

  logic [NUM_CH-1:0]       im_vec;
  logic [NUM_CH-1:0]       hit_vec;
  logic [NUM_CH-1:0]       pending;
  logic [NUM_CH-1:0]       w1c_mask;
  logic [NUM_CH-1:0][31:0] ctrl_word;
  logic [NUM_CH-1:0][31:0] preset_word;
  logic [NUM_CH-1:0][31:0] count_word;
  logic [NUM_CH-1:0][31:0] state_word;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(4 * c);
    localparam logic [ADDR_W-1:0] A_PRESET = ADDR_W'(4 * c + 1);

    logic             en;
    logic             im;
    logic [1:0]       mode;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    state_t           state;
    state_t           state_nxt;
    logic             wr_ctrl;
    logic             wr_preset;
    logic             do_load;
    logic             do_dec;
    logic             do_hit;
    logic             clr_en;

    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_preset = we && (addr == A_PRESET);

    // CTRL register; a bus write beats the one-shot EN clear on the same edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        en   <= 1'b0;
        mode <= 2'b00;
        im   <= 1'b0;
      end else if (wr_ctrl) begin
        en   <= wdata[0];
        mode <= wdata[2:1];
        im   <= wdata[3];
      end else if (clr_en) begin
        en   <= 1'b0;
      end
    end

    // PRESET register; only sampled by LOAD, so a running count is untouched.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)         preset <= '0;
      else if (wr_preset) preset <= wdata[CNT_W-1:0];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
    end

    // FSM next state; LOAD and INT always finish their single cycle.
    // NOTE: assigning a default first keeps always_comb free of inferred latches.
    always_comb begin
      state_nxt = state;
      unique case (state)
        S_IDLE: if (en) state_nxt = S_LOAD;
        S_LOAD: state_nxt = en ? S_CNT : S_IDLE;
        S_CNT: begin
          if (!en)                    state_nxt = S_IDLE;
          else if (count <= CNT_W'(1)) state_nxt = S_INT;
        end
        S_INT:  state_nxt = (en && mode == MODE_AUTO) ? S_LOAD : S_IDLE;
      endcase
    end

    // FSM outputs: counter controls, expiry strobe and the one-shot EN clear.
    always_comb begin
      do_load = (state == S_LOAD);
      do_dec  = (state == S_CNT) && en && (count > CNT_W'(1));
      do_hit  = (state == S_CNT) && en && (count <= CNT_W'(1));
      clr_en  = (state == S_INT) && (mode != MODE_AUTO);
    end

    // Counter: load, decrement, or force to zero on expiry (never wraps).
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)       count <= '0;
      else if (do_load) count <= preset;
      else if (do_dec)  count <= count - CNT_W'(1);
      else if (do_hit)  count <= '0;
    end

    assign ctrl_word[c]   = {28'd0, im, mode, en};
    assign preset_word[c] = 32'(preset);
    assign count_word[c]  = 32'(count);
    assign state_word[c]  = {30'd0, state};
    assign im_vec[c]      = im;
    assign hit_vec[c]     = do_hit;
  end

  assign w1c_mask = (we && addr == PEND_ADDR) ? wdata[NUM_CH-1:0] : '0;

  // Pending register; a hardware set wins over a same-edge write-1-to-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~w1c_mask) | hit_vec;
  end

  assign irq_vec = pending & im_vec;
  assign irq     = |irq_vec;

  // Zero-latency read mux; unmapped words read zero.
  always_comb begin
    rdata = '0;
    if (addr == PEND_ADDR) rdata[NUM_CH-1:0] = pending;
    for (int c = 0; c < NUM_CH; c++) begin
      if (addr[ADDR_W-1:2] == (ADDR_W-2)'(c)) begin
        unique case (addr[1:0])
          2'd0: rdata = ctrl_word[c];
          2'd1: rdata = preset_word[c];
          2'd2: rdata = count_word[c];
          2'd3: rdata = state_word[c];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank with NUM_CH=2, CNT_W=32, ADDR_W=5.
// Register accesses come from a vector table. The multi-cycle timer behaviour
// is covered by hand-written sequences. Expected counts are queued at stimulus
// time and popped as the DUT advances.
module tb_timer_bank;

  logic        clk;
  logic        reset;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  irq_vec;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  timer_bank #(.NUM_CH(2), .CNT_W(32), .ADDR_W(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_vec (irq_vec),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus write; it lands on the next rising edge, returns just after it.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    we    = 1'b1;
    wdata = d;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [31:0] ex, input string nm);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp = ex; v.name = nm;
    vecs.push_back(v);
  endtask

  initial begin
    logic [1:0] pm;
    logic       set_b;
    logic       w1c_b;

    reset = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;

    // Register-access vectors.
    for (int a = 0; a <= 9; a++) add_vec(1'b0, 5'd0, 32'd0, 5'(a), 32'd0, "reset_rd");
    add_vec(1'b1, 5'd1,  32'hDEADBEEF, 5'd1,  32'hDEADBEEF, "preset0_rw");
    add_vec(1'b1, 5'd0,  32'hFFFFFFF0, 5'd0,  32'h0,        "ctrl0_reserved");
    add_vec(1'b1, 5'd0,  32'hFFFFFFF6, 5'd0,  32'h6,        "ctrl0_mode");
    add_vec(1'b1, 5'd2,  32'hFFFFFFFF, 5'd2,  32'h0,        "count0_ro");
    add_vec(1'b1, 5'd3,  32'hFFFFFFFF, 5'd3,  32'h0,        "state0_ro");
    add_vec(1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 32'h0,        "unmapped31");
    add_vec(1'b1, 5'd9,  32'hFFFFFFFF, 5'd9,  32'h0,        "unmapped9");
    add_vec(1'b1, 5'd8,  32'h000000FF, 5'd8,  32'h0,        "pend_w1c_idle");
    add_vec(1'b0, 5'd0,  32'h0,        5'd1,  32'hDEADBEEF, "preset0_keep");
    add_vec(1'b1, 5'd5,  32'h12345678, 5'd5,  32'h12345678, "preset1_rw");
    add_vec(1'b1, 5'd4,  32'h0000000E, 5'd4,  32'hE,        "ctrl1_rw");
    add_vec(1'b0, 5'd0,  32'h0,        5'd7,  32'h0,        "state1_idle");
    add_vec(1'b1, 5'd0,  32'h0,        5'd0,  32'h0,        "ctrl0_clr");
    add_vec(1'b1, 5'd4,  32'h0,        5'd4,  32'h0,        "ctrl1_clr");

    repeat (3) @(posedge clk);
    #1;
    check("irq_in_reset", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    check("irq_after_reset", 32'(irq), 32'd0);
    check("irq_vec_after_reset", 32'(irq_vec), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
      rd_chk(vecs[i].raddr, vecs[i].exp, vecs[i].name);
    end

    // One-shot channel 0, PRESET=5: COUNT 5..0 over edges 2..7.
    wr(5'd1, 32'd5);
    wr(5'd0, 32'h9);                       // edge 0
    for (int v = 5; v >= 0; v--) exp_q.push_back(32'(v));
    tick(1);
    rd_chk(5'd3, 32'd1, "os_state_load");
    for (int e = 2; e <= 7; e++) begin
      tick(1);
      if (exp_q.size() == 0) check("os_queue_empty", 32'd1, 32'd0);
      else rd_chk(5'd2, exp_q.pop_front(), "os_count");
      check("os_irq", 32'(irq), (e == 7) ? 32'd1 : 32'd0);
    end
    check("os_irq_vec", 32'(irq_vec), 32'd1);
    rd_chk(5'd8, 32'd1, "os_pending");
    tick(1);                               // edge 8
    rd_chk(5'd0, 32'h8, "os_ctrl_en_cleared");
    rd_chk(5'd3, 32'd0, "os_state_idle");
    check("os_irq_level", 32'(irq), 32'd1);
    wr(5'd8, 32'h1);
    check("os_irq_w1c", 32'(irq), 32'd0);

    // Auto-reload channel 1, PRESET=3: set every 5 edges from edge 5.
    wr(5'd5, 32'd3);
    wr(5'd4, 32'hB);                       // edge 0
    pm = 2'b00;
    for (int e = 1; e <= 16; e++) begin
      w1c_b = (e == 7) || (e == 15);
      if (w1c_b) wr(5'd8, 32'h2);
      else       tick(1);
      set_b = (e >= 5) && (((e - 5) % 5) == 0);
      pm[1] = (pm[1] & ~w1c_b) | set_b;
      check("ar_irq", 32'(irq), 32'(pm[1]));
      check("ar_irq_vec", 32'(irq_vec), 32'(pm));
    end
    wr(5'd4, 32'h0);
    tick(2);
    wr(5'd8, 32'h2);
    rd_chk(5'd8, 32'd0, "ar_pending_cleared");
    rd_chk(5'd7, 32'd0, "ar_state_idle");
    check("ar_irq_off", 32'(irq), 32'd0);

    // Stop mid-count: channel 0 PRESET=100, EN cleared while COUNT=40.
    wr(5'd1, 32'd100);
    wr(5'd0, 32'h9);                       // edge 0
    tick(61);
    rd_chk(5'd2, 32'd41, "stop_count_e61");
    wr(5'd0, 32'h8);                       // edge 62
    rd_chk(5'd2, 32'd40, "stop_count_e62");
    tick(1);
    rd_chk(5'd3, 32'd0, "stop_state_idle");
    rd_chk(5'd2, 32'd40, "stop_count_hold");
    tick(5);
    rd_chk(5'd2, 32'd40, "stop_count_hold_late");
    rd_chk(5'd8, 32'd0, "stop_no_pending");
    check("stop_no_irq", 32'(irq), 32'd0);

    // Masking and independence: both channels expire with IM=0.
    wr(5'd1, 32'd2);
    wr(5'd5, 32'd2);
    wr(5'd0, 32'h1);
    wr(5'd4, 32'h1);
    tick(8);
    rd_chk(5'd8, 32'h3, "mask_pending");
    check("mask_irq", 32'(irq), 32'd0);
    check("mask_irq_vec", 32'(irq_vec), 32'd0);
    wr(5'd4, 32'h8);
    check("mask_irq_vec_ch1", 32'(irq_vec), 32'h2);
    check("mask_irq_ch1", 32'(irq), 32'd1);
    wr(5'd8, 32'h3);
    check("mask_irq_cleared", 32'(irq), 32'd0);
    wr(5'd4, 32'h0);

    // PRESET=0 gives one CNT cycle: interrupt after edge 3.
    wr(5'd1, 32'd0);
    wr(5'd0, 32'h9);                       // edge 0
    tick(2);
    check("p0_irq_e2", 32'(irq), 32'd0);
    rd_chk(5'd3, 32'd2, "p0_state_cnt");
    tick(1);
    check("p0_irq_e3", 32'(irq), 32'd1);

    // PRESET rewrite mid-count, then asynchronous reset mid-CNT.
    wr(5'd1, 32'd50);
    wr(5'd0, 32'h9);                       // edge 0
    tick(3);
    wr(5'd1, 32'd7);                       // edge 4
    rd_chk(5'd2, 32'd48, "preset_no_disturb");
    rd_chk(5'd3, 32'd2, "rst_pre_state_cnt");
    check("rst_pre_irq", 32'(irq), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_async_irq", 32'(irq), 32'd0);
    check("rst_async_irq_vec", 32'(irq_vec), 32'd0);
    rd_chk(5'd2, 32'd0, "rst_async_count");
    rd_chk(5'd3, 32'd0, "rst_async_state");
    rd_chk(5'd1, 32'd0, "rst_async_preset");
    rd_chk(5'd8, 32'd0, "rst_async_pending");
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    rd_chk(5'd3, 32'd0, "rst_needs_en");
    rd_chk(5'd0, 32'd0, "rst_ctrl_zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
